// File: rtl/wb_arbiter_pkg.sv
// CorePack: shared core types for the write-back path.
//   reg_ind_t  - architectural register index (x0..x31)
//   data_t     - register data word
//   wb_entry_t - one long-latency buffer slot {rd, data, live}
//   WB_BUF_DEPTH_MAX - largest supported long-latency buffer depth
package CorePack;
    localparam int XLEN = 32;

    typedef logic [4:0]      reg_ind_t;
    typedef logic [XLEN-1:0] data_t;

    typedef struct packed {
        reg_ind_t rd;
        data_t    data;
        logic     live;
    } wb_entry_t;

    localparam int WB_BUF_DEPTH_MAX = 4;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bus bundle between the result sources and the register
// file write port.
//   pipe_we/pipe_rd/pipe_data          - in-order pipeline write-back
//   mem_valid/mem_ready/mem_rd/mem_data - long-latency return handshake
//   rf_we/rf_waddr/rf_wdata            - register file write port
// modport master: the environment (sources + register file)
// modport slave : the arbiter
interface wb_arbiter_if;
    import CorePack::*;

    logic     pipe_we;
    reg_ind_t pipe_rd;
    data_t    pipe_data;
    logic     mem_valid;
    logic     mem_ready;
    reg_ind_t mem_rd;
    data_t    mem_data;
    logic     rf_we;
    reg_ind_t rf_waddr;
    data_t    rf_wdata;

    modport master (
        output pipe_we, pipe_rd, pipe_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, mem_valid, mem_rd, mem_data,
        output mem_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_arbiter_buf.sv
// wb_buf: in-order circular buffer for long-latency results.
//   clk, rst       - clock, async active-low reset
//   push/push_ent  - enqueue one entry at the tail
//   pop            - dequeue the head entry
//   kill/kill_rd   - clear the live bit of every stored entry with rd==kill_rd
//   head           - head entry (only meaningful when count != 0)
//   count          - number of occupied slots
//   pend_mask      - (WB_PEND_MASK_EN only) registers targeted by live entries
// Free slots always carry live=0, so the pending mask can OR over every slot
// without consulting the pointers.
module wb_buf
    import CorePack::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_ent,
    input  logic                   pop,
    input  logic                   kill,
    input  reg_ind_t               kill_rd,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count
`ifdef WB_PEND_MASK_EN
   ,output logic [31:0]            pend_mask
`endif
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t       ent [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    assign head = ent[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Order matters: kill, then pop clears the freed slot, then the
            // push writes its own (different) slot with its own live bit.
            for (int i = 0; i < DEPTH; i++)
                if (kill && ent[i].rd == kill_rd) ent[i].live <= 1'b0;
            if (pop) begin
                ent[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (push) begin
                ent[wr_ptr] <= push_ent;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_PEND_MASK_EN
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent[i].live) pend_mask[ent[i].rd] = 1'b1;
        pend_mask[0] = 1'b0;
    end
`endif
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline write-back and long-latency returns into the
// single register file write port.
//   clk, rst  - core clock, async active-low reset
//   bus       - wb_arbiter_if.slave (pipe_*, mem_* handshake, rf_* outputs)
//   pend_mask - pending-register mask, present only with WB_PEND_MASK_EN
// Slot priority: pipeline write > live buffer head > bypass of a transfer
// accepted into an empty buffer. A pipeline write kills buffered results
// (and a same-cycle transfer) to the same register.
module wb_arbiter
    import CorePack::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
`ifdef WB_PEND_MASK_EN
   ,output logic [31:0] pend_mask
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic          rdy_en;   // holds mem_ready low for the first cycle out of reset
    logic [CW-1:0] count;
    wb_entry_t     head;
    wb_entry_t     push_ent;
    logic          push;
    logic          pop;
    logic          pipe_take;
    logic          accept;
    logic          bypass;
    logic          out_we;
    reg_ind_t      out_rd;
    data_t         out_data;

    assign bus.mem_ready = rdy_en && (count < CW'(BUF_DEPTH));

    always_comb begin
        pipe_take = bus.pipe_we && (bus.pipe_rd != '0);
        accept    = bus.mem_valid && bus.mem_ready;
        bypass    = !pipe_take && (count == '0) && accept && (bus.mem_rd != '0);
        push      = accept && (bus.mem_rd != '0) && !bypass;
        // A transfer arriving alongside a pipe write to the same rd is older.
        push_ent  = '{rd: bus.mem_rd, data: bus.mem_data,
                      live: !(pipe_take && bus.mem_rd == bus.pipe_rd)};
        pop       = 1'b0;
        out_we    = 1'b0;
        out_rd    = '0;
        out_data  = '0;
        if (pipe_take) begin
            out_we   = 1'b1;
            out_rd   = bus.pipe_rd;
            out_data = bus.pipe_data;
        end else if (count != '0 && head.live) begin
            out_we   = 1'b1;
            out_rd   = head.rd;
            out_data = head.data;
            pop      = 1'b1;
        end else if (bypass) begin
            out_we   = 1'b1;
            out_rd   = bus.mem_rd;
            out_data = bus.mem_data;
        end
        // Dead heads leave without consuming the write slot.
        if (count != '0 && !head.live) pop = 1'b1;
    end

    wb_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_ent (push_ent),
        .pop      (pop),
        .kill     (pipe_take),
        .kill_rd  (bus.pipe_rd),
        .head     (head),
        .count    (count)
`ifdef WB_PEND_MASK_EN
       ,.pend_mask(pend_mask)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en       <= 1'b0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            rdy_en    <= 1'b1;
            bus.rf_we <= out_we;
            if (out_we) begin
                bus.rf_waddr <= out_rd;
                bus.rf_wdata <= out_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (BUF_DEPTH=2). Inputs change 1ns after a
// rising edge; outputs are sampled at that same point, i.e. they show the
// result of the edge just passed.
module tb_wb_arbiter;
    import CorePack::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wb_arbiter_if bus();
`ifdef WB_PEND_MASK_EN
    logic [31:0] pend_mask;
`endif

    wb_arbiter #(.BUF_DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef WB_PEND_MASK_EN
       ,.pend_mask(pend_mask)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input reg_ind_t rd, input data_t d);
        bus.pipe_we = we; bus.pipe_rd = rd; bus.pipe_data = d;
    endtask

    task automatic mem(input logic v, input reg_ind_t rd, input data_t d);
        bus.mem_valid = v; bus.mem_rd = rd; bus.mem_data = d;
    endtask

    task automatic out(input string tag, input logic we, input reg_ind_t a, input data_t d);
        chk({tag, ".we"}, 32'(bus.rf_we), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(bus.rf_waddr), 32'(a));
            chk({tag, ".data"}, bus.rf_wdata, d);
        end
    endtask

    task automatic pend(input string tag, input logic [31:0] exp);
`ifdef WB_PEND_MASK_EN
        chk(tag, pend_mask, exp);
`else
        if (exp === 32'hx) $error("bad pend arg");
`endif
    endtask

    initial begin
        pipe(0, 0, 0);
        mem(1, 5'd4, 32'h44);
        // Reset held with an offer present.
        for (int i = 0; i < 3; i++) begin
            tick();
            out("rst_we", 0, 0, 0);
            chk("rst_ready", 32'(bus.mem_ready), 0);
            pend("rst_pend", 0);
        end
        chk("rst_waddr", 32'(bus.rf_waddr), 0);
        chk("rst_wdata", bus.rf_wdata, 0);
        mem(0, 0, 0);
        rst = 1'b1;
        #1 chk("rel_ready0", 32'(bus.mem_ready), 0);
        tick();
        chk("rel_ready1", 32'(bus.mem_ready), 1);
        out("rel_idle", 0, 0, 0);

        // Plain pipeline write, then x0 write ignored.
        pipe(1, 5'd5, 32'h1234);
        tick(); out("pipe5", 1, 5, 32'h1234);
        pipe(1, 5'd0, 32'h5555);
        tick(); out("pipe_x0", 0, 0, 0);

        // Mem x7 collides with pipe x3.
        pipe(1, 5'd3, 32'hBB); mem(1, 5'd7, 32'hAA);
        tick(); out("coll_n", 1, 3, 32'hBB); pend("coll_pend1", 32'h80);
        chk("coll_ready", 32'(bus.mem_ready), 1);
        pipe(0, 0, 0); mem(0, 0, 0);
        tick(); out("coll_n1", 1, 7, 32'hAA); pend("coll_pend0", 0);
        tick(); out("coll_idle", 0, 0, 0);

        // Fill with pipe writes every cycle.
        pipe(1, 5'd1, 32'h10); mem(1, 5'd10, 32'hA0);
        tick(); out("fill0", 1, 1, 32'h10);
        pipe(1, 5'd1, 32'h11); mem(1, 5'd11, 32'hA1);
        tick(); out("fill1", 1, 1, 32'h11);
        chk("fill_full", 32'(bus.mem_ready), 0);
        pend("fill_pend", 32'h0C00);
        pipe(1, 5'd1, 32'h12); mem(1, 5'd12, 32'hA2);
        tick(); out("fill2", 1, 1, 32'h12);
        chk("fill_full2", 32'(bus.mem_ready), 0);
        pipe(0, 0, 0);
        tick(); out("drain0", 1, 10, 32'hA0);
        chk("drain_ready", 32'(bus.mem_ready), 1);
        tick(); out("drain1", 1, 11, 32'hA1);
        mem(0, 0, 0);
        tick(); out("drain2", 1, 12, 32'hA2);
        tick(); out("drain_idle", 0, 0, 0);

        // Kill a buffered entry.
        pipe(1, 5'd2, 32'h77); mem(1, 5'd9, 32'h1);
        tick(); out("kill_p2", 1, 2, 32'h77);
        pipe(1, 5'd9, 32'h2); mem(0, 0, 0);
        tick(); out("kill_p9", 1, 9, 32'h2); pend("kill_pend", 0);
        pipe(0, 0, 0);
        tick(); out("kill_pop", 0, 0, 0);
        chk("kill_hold", bus.rf_wdata, 32'h2);
        tick(); out("kill_idle", 0, 0, 0);

        // Same-cycle transfer to the pipe's rd is enqueued dead.
        pipe(1, 5'd6, 32'h66); mem(1, 5'd6, 32'h99);
        tick(); out("samekill", 1, 6, 32'h66); pend("samekill_pend", 0);
        pipe(0, 0, 0); mem(0, 0, 0);
        tick(); out("samekill_pop", 0, 0, 0);
        tick(); out("samekill_idle", 0, 0, 0);

        // mem_rd=0 handshakes but is dropped; then bypass.
        mem(1, 5'd0, 32'hDD);
        tick(); out("mem_x0", 0, 0, 0);
        mem(1, 5'd8, 32'hCC);
        tick(); out("bypass", 1, 8, 32'hCC); pend("bypass_pend", 0);
        mem(0, 0, 0);
        tick(); out("bypass_idle", 0, 0, 0);

        // Reset while the buffer holds two entries.
        pipe(1, 5'd1, 32'h20); mem(1, 5'd13, 32'hB3);
        tick();
        mem(1, 5'd14, 32'hB4);
        tick(); chk("mid_full", 32'(bus.mem_ready), 0);
        pipe(0, 0, 0); mem(0, 0, 0);
        rst = 1'b0;
        #1 out("mid_rst", 0, 0, 0);
        chk("mid_rst_ready", 32'(bus.mem_ready), 0);
        pend("mid_rst_pend", 0);
        tick(); out("mid_rst_hold", 0, 0, 0);
        rst = 1'b1;
        tick(); out("mid_rel", 0, 0, 0);
        chk("mid_rel_ready", 32'(bus.mem_ready), 1);
        tick(); out("mid_empty", 0, 0, 0);
        pipe(1, 5'd1, 32'h21); mem(1, 5'd15, 32'hB5);
        tick(); chk("mid_cnt1", 32'(bus.mem_ready), 1);
        pipe(0, 0, 0); mem(0, 0, 0);
        tick(); out("mid_drain", 1, 15, 32'hB5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
